// File: rtl/arc4_encrypt.sv
// -----------------------------------------------------------------------------
// arc4_encrypt
//   ARC4 encryption engine. On an accepted start it:
//     1. initialises the external S memory to the identity permutation,
//     2. runs the key-scheduling pass using a 24-bit (3-byte) key,
//     3. reads the length byte L from plaintext memory and copies it to ct[0],
//     4. generates L keystream bytes and writes ct[k] = pt[k] ^ pad.
//   One memory access per cycle, every read is issued, waited on, then used.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   en / rdy        start request, accepted only while rdy=1
//   key[23:0]       key bytes {k0,k1,k2}; latched when en is accepted
//   s_*             S memory port (256x8), 1-cycle read latency
//   pt_addr/rddata  plaintext memory read port, 1-cycle read latency
//   ct_*            ciphertext memory write port
// All memory-facing outputs are registered.
// -----------------------------------------------------------------------------
module arc4_encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_INIT,
        S_KA, S_KB, S_KC, S_KD, S_KE, S_KF,
        S_LA, S_LB, S_LC,
        S_PA, S_PB, S_PC, S_PD, S_PE, S_PF, S_PG, S_PH, S_PI,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rdy_q, rdy_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  k_q, k_d;
    logic [1:0]  kidx_q, kidx_d;      // i mod 3, tracked alongside i during KSA
    logic [7:0]  len_q, len_d;
    logic [7:0]  si_q, si_d;          // S[i] as read before the swap
    logic [7:0]  sj_q, sj_d;          // S[j] as read before the swap
    logic [7:0]  ptb_q, ptb_d;        // plaintext byte for the current k
    logic [7:0]  s_addr_q, s_addr_d;
    logic [7:0]  s_wrdata_q, s_wrdata_d;
    logic        s_wren_q, s_wren_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic [7:0]  ct_addr_q, ct_addr_d;
    logic [7:0]  ct_wrdata_q, ct_wrdata_d;
    logic        ct_wren_q, ct_wren_d;

    logic [7:0]  key_byte;
    logic [7:0]  ksa_j;

    always_comb begin
        case (kidx_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // Sum truncates to 8 bits: all index arithmetic is modulo 256.
    assign ksa_j = j_q + s_rddata + key_byte;

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        key_d       = key_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        kidx_d      = kidx_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        ptb_d       = ptb_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;           // write strobes are single-cycle
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    key_d   = key;
                    rdy_d   = 1'b0;
                    i_d     = 8'd0;
                    state_d = S_INIT;
                end
            end

            // S[i] = i; i wraps to 0 after 255, ready for KSA.
            S_INIT: begin
                s_addr_d   = i_q;
                s_wrdata_d = i_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    state_d = S_KA;
                end
            end

            // KSA: read S[i], read S[j], write S[i]=sj, write S[j]=si.
            S_KA: begin
                s_addr_d = i_q;
                state_d  = S_KB;
            end
            S_KB: state_d = S_KC;
            S_KC: begin
                si_d     = s_rddata;
                j_d      = ksa_j;
                s_addr_d = ksa_j;
                state_d  = S_KD;
            end
            S_KD: state_d = S_KE;
            S_KE: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = S_KF;
            end
            S_KF: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                kidx_d     = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                state_d    = (i_q == 8'hFF) ? S_LA : S_KA;
            end

            // Length byte: read pt[0], mirror it into ct[0].
            S_LA: begin
                pt_addr_d = 8'd0;
                state_d   = S_LB;
            end
            S_LB: state_d = S_LC;
            S_LC: begin
                len_d       = pt_rddata;
                ct_addr_d   = 8'd0;
                ct_wrdata_d = pt_rddata;
                ct_wren_d   = 1'b1;
                i_d         = 8'd0;
                j_d         = 8'd0;
                k_d         = 8'd1;
                state_d     = (pt_rddata == 8'd0) ? S_DONE : S_PA;
            end

            // PRGA, one keystream byte per pass; pt[k] is fetched in
            // parallel with S[i].
            S_PA: begin
                i_d       = i_q + 8'd1;
                s_addr_d  = i_q + 8'd1;
                pt_addr_d = k_q;
                state_d   = S_PB;
            end
            S_PB: state_d = S_PC;
            S_PC: begin
                si_d     = s_rddata;
                ptb_d    = pt_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
                state_d  = S_PD;
            end
            S_PD: state_d = S_PE;
            S_PE: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = S_PF;
            end
            S_PF: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = S_PG;
            end
            // After the swap S[i]=sj and S[j]=si, so their sum is si+sj
            // regardless of order; no re-read needed.
            S_PG: begin
                s_addr_d = si_q + sj_q;
                state_d  = S_PH;
            end
            S_PH: state_d = S_PI;
            S_PI: begin
                ct_addr_d   = k_q;
                ct_wrdata_d = ptb_q ^ s_rddata;
                ct_wren_d   = 1'b1;
                k_d         = k_q + 8'd1;
                state_d     = (k_q == len_q) ? S_DONE : S_PA;
            end

            S_DONE: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b1;
            key_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            kidx_q      <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            ptb_q       <= '0;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            key_q       <= key_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            kidx_q      <= kidx_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            ptb_q       <= ptb_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// -----------------------------------------------------------------------------
// tb_arc4_encrypt
//   Scoreboarded bench for arc4_encrypt. Stimulus tasks push the expected
//   ciphertext writes (address, data) into a queue; an independent monitor
//   pops and compares on every ct write. Expected bytes come from a plain
//   software ARC4 model, fixed known vectors, or the original plaintext
//   (round trip).
// -----------------------------------------------------------------------------
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .s_rddata  (s_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    // Memories: synchronous, 1-cycle read latency.
    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end

    int total  = 0;
    int passed = 0;
    logic [15:0] exp_q [$];          // {addr, data} of each expected ct write
    logic [7:0]  model_s [256];      // S contents after the modelled KSA+PRGA

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && ct_wren) begin
            check("wren_exclusive", 32'(s_wren & ct_wren), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL ct_extra_write: addr %h data %h, no write expected", ct_addr, ct_wrdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("ct_addr", 32'(ct_addr), 32'(e[15:8]));
                check("ct_data", 32'(ct_wrdata), 32'(e[7:0]));
            end
        end
    end

    // Software ARC4 on the current pt_mem contents.
    task automatic model_run(input logic [23:0] k);
        int s [256];
        int i, j, t, len;
        logic [7:0] kb, pad;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = (j + s[i] + int'(kb)) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        len = int'(pt_mem[0]);
        exp_q.push_back({8'h00, pt_mem[0]});
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            pad = 8'(s[(s[i] + s[j]) % 256]);
            exp_q.push_back({8'(n), pt_mem[n] ^ pad});
        end
        for (int n = 0; n < 256; n++) model_s[n] = 8'(s[n]);
    endtask

    task automatic wait_rdy(input int budget, input string name);
        int cnt = 0;
        while (!rdy && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check(name, 32'(rdy), 32'd1);
    endtask

    // One run; optional 'disturb' pulses en and changes key while busy.
    task automatic do_run(input logic [23:0] k, input int budget, input bit disturb);
        int cnt = 0;
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("rdy_low_after_en", 32'(rdy), 32'd0);
        while (!rdy && cnt < budget) begin
            if (disturb && cnt == 50) begin
                en  = 1'b1;
                key = ~k;
            end else if (disturb && cnt == 51) begin
                en  = 1'b0;
                key = k ^ 24'h123456;
            end
            @(negedge clk);
            cnt++;
        end
        en = 1'b0;
        check("run_done_in_budget", 32'(rdy), 32'd1);
        check("ct_writes_all_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_s_final(input string name);
        int bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== model_s[n]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    function automatic int budget_for(input int len);
        return 256 + 1536 + 3 + 9 * len + 2 + 4;
    endfunction

    logic [7:0] kv_pt [10];
    logic [7:0] kv_ct [10];
    logic [7:0] orig  [256];

    task automatic load_known;
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
    endtask

    task automatic load_random(input int len);
        pt_mem[0] = 8'(len);
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] ka, kb2;
        int len;
        kv_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        kv_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        rst = 1'b1;
        en  = 1'b0;
        key = '0;
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_rdy",     32'(rdy),       32'd1);
        check("reset_s_wren",  32'(s_wren),    32'd0);
        check("reset_ct_wren", 32'(ct_wren),   32'd0);
        check("reset_addrs",   32'({s_addr, pt_addr, ct_addr}), 32'd0);
        check("reset_wrdata",  32'({s_wrdata, ct_wrdata}),      32'd0);
        rst = 1'b0;

        // Reset in the middle of KSA: no ct writes expected.
        load_known();
        @(negedge clk);
        key = 24'h4B6579;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy",   32'(rdy), 32'd1);
        check("midrst_wrens", 32'({s_wren, ct_wren}), 32'd0);
        rst = 1'b0;

        // Known vector after the aborted run.
        for (int n = 0; n < 10; n++) exp_q.push_back({8'(n), kv_ct[n]});
        do_run(24'h4B6579, budget_for(9), 1'b0);

        // Zero length.
        pt_mem[0] = 8'h00;
        ka = 24'($urandom());
        model_run(ka);
        do_run(ka, 1800, 1'b0);
        check_s_final("zero_len_s_final");

        // Maximum length.
        load_random(255);
        model_run(24'hFFFFFA);
        do_run(24'hFFFFFA, budget_for(255), 1'b0);

        // en pulsed and key changed while busy.
        len = $urandom_range(1, 40);
        load_random(len);
        ka = 24'($urandom());
        model_run(ka);
        do_run(ka, budget_for(len), 1'b1);

        // en held high across two runs with different keys.
        len = $urandom_range(1, 30);
        load_random(len);
        ka  = 24'($urandom());
        kb2 = ka ^ 24'h5A5A01;
        model_run(ka);
        model_run(kb2);
        @(negedge clk);
        key = ka;
        en  = 1'b1;
        @(negedge clk);
        check("b2b_rdy_low_1", 32'(rdy), 32'd0);
        key = kb2;
        wait_rdy(budget_for(len), "b2b_run1_done");
        @(negedge clk);
        check("b2b_rdy_low_2", 32'(rdy), 32'd0);
        en = 1'b0;
        wait_rdy(budget_for(len), "b2b_run2_done");
        check("b2b_ct_all_seen", 32'(exp_q.size()), 32'd0);
        check_s_final("b2b_s_final");

        // Round trip: ct fed back as pt reproduces the plaintext.
        len = $urandom_range(1, 255);
        load_random(len);
        for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
        model_run(24'h000018);
        do_run(24'h000018, budget_for(len), 1'b0);
        for (int n = 0; n <= len; n++) pt_mem[n] = ct_mem[n];
        for (int n = 0; n <= len; n++) exp_q.push_back({8'(n), orig[n]});
        do_run(24'h000018, budget_for(len), 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
